rec_sram_writer: RTL and testbench

REC_SRAM_WRITER -- requirements
Module: rec_sram_writer

---
 rtl/rec_sram_writer_pkg.sv | 20 ++
 rtl/rec_sram_writer.sv | 150 +++++++++++++++
 tb/tb_rec_sram_writer.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/rec_sram_writer_pkg.sv
// Shared audio/recorder definitions: SRAM widths, writer FSM states and the
// captured-sample record used by the recorder SRAM writer.
package rec_sram_writer_pkg;

  localparam int SRAM_ADDR_W = 20;
  localparam int SAMPLE_W    = 16;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_WRITE = 2'd2,
    S_HOLD  = 2'd3
  } wr_state_e;

  typedef struct packed {
    logic [SRAM_ADDR_W-1:0] addr;
    logic [SAMPLE_W-1:0]    data;
  } sample_t;

endpackage

// File: rtl/rec_sram_writer.sv
// Recorder SRAM writer: captures each completed sample on an address increment
// and writes it to asynchronous SRAM; optional REC_WRITER_OVF_EN drops on overflow.
module rec_sram_writer
  import rec_sram_writer_pkg::*;
#(
  parameter int WE_CYCLES = 2
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_enable,
  input  logic [SRAM_ADDR_W-1:0] i_rec_address,
  input  logic [SAMPLE_W-1:0]    i_rec_data,
  output logic [SRAM_ADDR_W-1:0] o_sram_addr,
  output logic [SAMPLE_W-1:0]    o_sram_dq,
  output logic                   o_dq_oe,
  output logic                   o_sram_we_n,
  output logic                   o_sram_ce_n,
  output logic                   o_sram_oe_n,
  output logic                   o_sram_lb_n,
  output logic                   o_sram_ub_n,
  output logic                   o_busy,
  output logic                   o_overflow
);

  localparam logic [3:0] WE_LAST = 4'(WE_CYCLES - 1);

  wr_state_e              state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [SRAM_ADDR_W-1:0] prev_addr_q;
  sample_t                cur_q, cur_d;
  sample_t                pend_q, pend_d;
  logic                   pend_full_q, pend_full_d;
  logic                   ovf_q, ovf_d;
  logic                   we_n_q, ce_n_q, dq_oe_q, busy_q;
  logic                   capture_s;
  sample_t                cap_s;
  logic                   load_pend_s, load_cap_s;

  // The sample just completed belongs to the address the recorder is leaving.
  assign capture_s = i_enable && (i_rec_address == prev_addr_q + 20'd1);
  assign cap_s     = {prev_addr_q, i_rec_data};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cur_d       = cur_q;
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    ovf_d       = ovf_q;
    load_pend_s = 1'b0;
    load_cap_s  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (pend_full_q) begin
          state_d     = S_SETUP;
          load_pend_s = 1'b1;
        end else if (capture_s) begin
          state_d    = S_SETUP;
          load_cap_s = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SETUP: begin
        state_d = S_WRITE;
        cnt_d   = 4'd0;
      end
      S_WRITE: begin
        if (cnt_q == WE_LAST) begin
          state_d = S_HOLD;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_HOLD: begin
        if (pend_full_q) begin
          state_d     = S_SETUP;
          load_pend_s = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (load_pend_s) begin
      cur_d       = pend_q;
      pend_full_d = 1'b0;
    end else if (load_cap_s) begin
      cur_d = cap_s;
    end else begin
      cur_d = cur_q;
    end

    // A slot being drained this cycle is free for the new capture.
    if (capture_s && !load_cap_s) begin
      if (!pend_full_q || load_pend_s) begin
        pend_d      = cap_s;
        pend_full_d = 1'b1;
      end else begin
`ifdef REC_WRITER_OVF_EN
        ovf_d = 1'b1;
`else
        pend_d = cap_s;
`endif
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      prev_addr_q <= '0;
      cur_q       <= '0;
      pend_q      <= '0;
      pend_full_q <= 1'b0;
      ovf_q       <= 1'b0;
      we_n_q      <= 1'b1;
      ce_n_q      <= 1'b1;
      dq_oe_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      prev_addr_q <= i_rec_address;
      cur_q       <= cur_d;
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
      ovf_q       <= ovf_d;
      we_n_q      <= (state_d != S_WRITE);
      ce_n_q      <= (state_d == S_IDLE);
      dq_oe_q     <= (state_d != S_IDLE);
      busy_q      <= (state_d != S_IDLE) || pend_full_d;
    end
  end

  assign o_sram_addr = cur_q.addr;
  assign o_sram_dq   = cur_q.data;
  assign o_dq_oe     = dq_oe_q;
  assign o_sram_we_n = we_n_q;
  assign o_sram_ce_n = ce_n_q;
  assign o_sram_oe_n = 1'b1;
  assign o_sram_lb_n = 1'b0;
  assign o_sram_ub_n = 1'b0;
  assign o_busy      = busy_q;
  assign o_overflow  = ovf_q;

endmodule

// File: tb/tb_rec_sram_writer.sv
// Randomised scoreboard bench for rec_sram_writer; honours REC_WRITER_OVF_EN.
module tb_rec_sram_writer;

  localparam int WE = 2;
  localparam int L  = WE + 2;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        en    = 1'b0;
  logic [19:0] addr  = 20'd0;
  logic [15:0] data  = 16'd0;

  logic [19:0] o_sram_addr;
  logic [15:0] o_sram_dq;
  logic        o_dq_oe, o_sram_we_n, o_sram_ce_n, o_sram_oe_n;
  logic        o_sram_lb_n, o_sram_ub_n, o_busy, o_overflow;

  rec_sram_writer #(.WE_CYCLES(WE)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_enable      (en),
    .i_rec_address (addr),
    .i_rec_data    (data),
    .o_sram_addr   (o_sram_addr),
    .o_sram_dq     (o_sram_dq),
    .o_dq_oe       (o_dq_oe),
    .o_sram_we_n   (o_sram_we_n),
    .o_sram_ce_n   (o_sram_ce_n),
    .o_sram_oe_n   (o_sram_oe_n),
    .o_sram_lb_n   (o_sram_lb_n),
    .o_sram_ub_n   (o_sram_ub_n),
    .o_busy        (o_busy),
    .o_overflow    (o_overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [19:0] a;
    logic [15:0] d;
    int          fall;
  } wr_t;

  wr_t exp_q[$];
  int  n_checks = 0;
  int  n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
  endtask

  // Reference model: one write engine occupying SETUP+WE+HOLD cycles plus a
  // one-entry waiting slot; times are in bench cycles.
  logic [19:0] m_prev;
  int          m_busy_until;
  bit          m_pend_v;
  wr_t         m_pend;
  int          m_pend_start;
  bit          m_ovf;

  task automatic model_reset();
    m_prev       = 20'd0;
    m_busy_until = -100;
    m_pend_v     = 1'b0;
    m_ovf        = 1'b0;
    exp_q.delete();
  endtask

  task automatic model_retire(input int c);
    if (m_pend_v && m_pend_start <= c + 1) begin
      m_pend.fall = m_pend_start + 1;
      exp_q.push_back(m_pend);
      m_busy_until = m_pend_start + L - 1;
      m_pend_v     = 1'b0;
    end
  endtask

  task automatic model_cycle(input int c, input logic [19:0] a, input logic [15:0] d, input logic e);
    int s;
    model_retire(c);
    if (e && a == m_prev + 20'd1) begin
      s = c + 1;
      if (m_busy_until + 1 + ((c == m_busy_until) ? 1 : 0) > s)
        s = m_busy_until + 1 + ((c == m_busy_until) ? 1 : 0);
      if (m_pend_v) begin
`ifdef REC_WRITER_OVF_EN
        m_ovf = 1'b1;
`else
        m_pend.a     = m_prev;
        m_pend.d     = d;
        m_pend_start = s;
`endif
      end else begin
        m_pend_v     = 1'b1;
        m_pend.a     = m_prev;
        m_pend.d     = d;
        m_pend_start = s;
      end
      model_retire(c);
    end
    m_prev = a;
  endtask

  task automatic step(input logic [19:0] a, input logic [15:0] d, input logic e);
    @(posedge clk);
    #1;
    addr = a;
    data = d;
    en   = e;
    model_cycle(cyc, a, d, e);
  endtask

  task automatic idle(input int n);
    repeat (n) step(addr, 16'h0000, 1'b0);
  endtask

  task automatic drain_and_check(input string tag);
    idle(3 * L + 4);
    check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_busy_idle"}, o_busy, 1'b0);
    check({tag, "_ce_n_idle"}, o_sram_ce_n, 1'b1);
    check({tag, "_overflow"}, o_overflow, m_ovf);
  endtask

  // Monitor: every falling edge of we_n is one SRAM write to score.
  logic mon_prev_we = 1'b1;
  bit   mon_in_wr   = 1'b0;
  int   mon_len     = 0;

  task automatic score_write();
    wr_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      $display("FAIL unexpected_write: addr=0x%0h dq=0x%0h at cycle %0d, none expected",
               o_sram_addr, o_sram_dq, cyc);
    end else begin
      e = exp_q.pop_front();
      check("write_addr", o_sram_addr, e.a);
      check("write_dq", o_sram_dq, e.d);
      check("write_start_cycle", cyc, e.fall);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      mon_prev_we <= 1'b1;
      mon_in_wr   <= 1'b0;
      mon_len     <= 0;
    end else begin
      if (!o_sram_we_n) begin
        check("ce_n_in_write", o_sram_ce_n, 1'b0);
        check("dq_oe_in_write", o_dq_oe, 1'b1);
        check("oe_n_in_write", o_sram_oe_n, 1'b1);
        if (mon_prev_we) begin
          score_write();
          mon_in_wr <= 1'b1;
          mon_len   <= 1;
        end else begin
          mon_len <= mon_len + 1;
        end
      end else if (mon_in_wr) begin
        check("we_low_cycles", mon_len, WE);
        mon_in_wr <= 1'b0;
      end
      mon_prev_we <= o_sram_we_n;
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_we_n"}, o_sram_we_n, 1'b1);
    check({tag, "_ce_n"}, o_sram_ce_n, 1'b1);
    check({tag, "_oe_n"}, o_sram_oe_n, 1'b1);
    check({tag, "_lb_ub"}, {o_sram_lb_n, o_sram_ub_n}, 2'b00);
    check({tag, "_dq_oe"}, o_dq_oe, 1'b0);
    check({tag, "_addr"}, o_sram_addr, 20'd0);
    check({tag, "_dq"}, o_sram_dq, 16'd0);
    check({tag, "_busy"}, o_busy, 1'b0);
    check({tag, "_overflow"}, o_overflow, 1'b0);
  endtask

  initial begin
    logic [19:0] na;
    bit          found;
    int          r;

    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    model_reset();

    // 0 -> 1 with 0x1234: write of address 0
    step(20'd1, 16'h1234, 1'b1);
    drain_and_check("basic");

    // jump 1->5, 5->0 (no write), then 0->1 writes address 0
    step(20'd5, 16'h1111, 1'b1);
    step(20'd0, 16'h2222, 1'b1);
    idle(2);
    step(20'd1, 16'h3333, 1'b1);
    drain_and_check("jump");

    // two captures two cycles apart
    step(20'd10, 16'h0000, 1'b1);
    step(20'd11, 16'hAAAA, 1'b1);
    step(20'd11, 16'h0000, 1'b1);
    step(20'd12, 16'hBBBB, 1'b1);
    drain_and_check("two_apart");

    // three consecutive captures: third dropped or overwrites
    step(20'd20, 16'h0000, 1'b1);
    step(20'd21, 16'hC001, 1'b1);
    step(20'd22, 16'hC002, 1'b1);
    step(20'd23, 16'hC003, 1'b1);
    drain_and_check("three_back");

    // enable low on an increment during an in-flight write
    step(20'd40, 16'h0000, 1'b1);
    step(20'd41, 16'hD001, 1'b1);
    step(20'd42, 16'hD002, 1'b0);
    drain_and_check("enable_low");

    // wrap from 0xFFFFF to 0
    step(20'hFFFFF, 16'h0000, 1'b1);
    step(20'h00000, 16'hE0E0, 1'b1);
    drain_and_check("wrap");

    // randomised traffic
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 9);
      if (r < 6)      na = addr + 20'd1;
      else if (r < 8) na = addr;
      else            na = 20'($urandom);
      step(na, 16'($urandom), ($urandom_range(0, 7) != 0));
    end
    drain_and_check("random");

    // reset during S_WRITE aborts the write at once
    step(addr + 20'd1, 16'hA5A5, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (!o_sram_we_n) found = 1'b1;
    end
    check("reach_write_before_reset", found, 1'b1);
    #1;
    check("busy_in_write", o_busy, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midwrite_reset");
    addr = 20'd0;
    en   = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();

    // first capture after reset compares against prev_addr = 0
    step(20'd1, 16'h5A5A, 1'b1);
    drain_and_check("post_reset");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
